// File: rtl/multicycle_control_pkg.sv
// Shared types and constants for the multi-cycle MIPS control unit.
// Holds the state enum, opcode/funct codes, datapath select encodings.
package mips_ctrl_pkg;

    typedef enum logic [3:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_MEM_ADDR,
        S_MEM_RD,
        S_MEM_WB,
        S_MEM_WR,
        S_EXEC_R,
        S_R_WB,
        S_EXEC_I,
        S_I_WB,
        S_BRANCH,
        S_JUMP,
        S_JAL,
        S_JR,
        S_TRAP
    } state_e;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_XORI  = 6'h0E;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] FN_JR    = 6'h08;

    localparam logic [2:0] ALU_ADD   = 3'd0;
    localparam logic [2:0] ALU_SUB   = 3'd1;
    localparam logic [2:0] ALU_FUNCT = 3'd2;
    localparam logic [2:0] ALU_AND   = 3'd3;
    localparam logic [2:0] ALU_OR    = 3'd4;
    localparam logic [2:0] ALU_XOR   = 3'd5;

    localparam logic [1:0] SRCB_REG    = 2'd0;
    localparam logic [1:0] SRCB_FOUR   = 2'd1;
    localparam logic [1:0] SRCB_IMM    = 2'd2;
    localparam logic [1:0] SRCB_IMM_SH = 2'd3;

    localparam logic [1:0] PCS_ALU    = 2'd0;
    localparam logic [1:0] PCS_ALUOUT = 2'd1;
    localparam logic [1:0] PCS_JUMP   = 2'd2;
    localparam logic [1:0] PCS_REG    = 2'd3;

    localparam logic [1:0] RD_RT = 2'd0;
    localparam logic [1:0] RD_RD = 2'd1;
    localparam logic [1:0] RD_RA = 2'd2;

    localparam logic [1:0] M2R_ALU = 2'd0;
    localparam logic [1:0] M2R_MDR = 2'd1;
    localparam logic [1:0] M2R_PC  = 2'd2;

    function automatic state_e decode_next(
        input logic [5:0] op,
        input logic [5:0] fn
    );
        state_e nxt;
        case (op)
            OP_RTYPE: nxt = (fn == FN_JR) ? S_JR : S_EXEC_R;
            OP_LW, OP_SW: nxt = S_MEM_ADDR;
            OP_BEQ, OP_BNE: nxt = S_BRANCH;
            OP_J: nxt = S_JUMP;
            OP_JAL: nxt = S_JAL;
            OP_ADDI, OP_ADDIU, OP_ANDI,
            OP_ORI, OP_XORI: nxt = S_EXEC_I;
            default: nxt = S_TRAP;
        endcase
        return nxt;
    endfunction

    function automatic logic [2:0] imm_alu_op(input logic [5:0] op);
        logic [2:0] aop;
        case (op)
            OP_ANDI: aop = ALU_AND;
            OP_ORI: aop = ALU_OR;
            OP_XORI: aop = ALU_XOR;
            default: aop = ALU_ADD;
        endcase
        return aop;
    endfunction

    function automatic logic imm_zero_ext(input logic [5:0] op);
        return (op == OP_ANDI) || (op == OP_ORI) || (op == OP_XORI);
    endfunction

endpackage

// File: rtl/multicycle_control_if.sv
// Control/status bundle between the multi-cycle controller and datapath.
// The controller uses the master side, the datapath the slave side.
interface multicycle_control_if #(
    parameter int CNT_W = 32
);
    logic [5:0]       opcode;
    logic [5:0]       funct;
    logic             zero;
    logic             mem_ready;
    logic             pc_write;
    logic             pc_write_cond;
    logic             branch_ne;
    logic             iord;
    logic             mem_read;
    logic             mem_write;
    logic             ir_write;
    logic             reg_write;
    logic [1:0]       reg_dst;
    logic [1:0]       mem_to_reg;
    logic             alu_src_a;
    logic [1:0]       alu_src_b;
    logic             zero_ext;
    logic [2:0]       alu_op;
    logic [1:0]       pc_source;
    logic             illegal_op;
    logic             mem_abort;
    logic [CNT_W-1:0] retired;
    logic [3:0]       state;

    modport master (
        input  opcode, funct, zero, mem_ready,
        output pc_write, pc_write_cond, branch_ne, iord,
        output mem_read, mem_write, ir_write, reg_write,
        output reg_dst, mem_to_reg, alu_src_a, alu_src_b,
        output zero_ext, alu_op, pc_source,
        output illegal_op, mem_abort, retired, state
    );

    modport slave (
        output opcode, funct, zero, mem_ready,
        input  pc_write, pc_write_cond, branch_ne, iord,
        input  mem_read, mem_write, ir_write, reg_write,
        input  reg_dst, mem_to_reg, alu_src_a, alu_src_b,
        input  zero_ext, alu_op, pc_source,
        input  illegal_op, mem_abort, retired, state
    );
endinterface

// File: rtl/multicycle_control_mem_wait_timer.sv
// Memory wait counter: counts stalled cycles, flags the timeout cycle.
// Any cycle that is not a stall clears it, so each access starts at zero.
module mem_wait_timer #(
    parameter int MEM_TIMEOUT = 15
) (
    input  logic clk,
    input  logic rst_n,
    input  logic waiting,
    output logic timeout
);
    localparam logic [7:0] LIMIT = 8'(MEM_TIMEOUT);

    logic [7:0] cnt_q;
    logic [7:0] cnt_d;

    assign timeout = waiting && (cnt_q == LIMIT);

    always_comb begin
        cnt_d = '0;
        if (waiting && !timeout) begin
            cnt_d = cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle MIPS control FSM with memory handshake, opcode trap,
// timeout abort and retired-instruction counter.
module multicycle_control
    import mips_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 15,
    parameter int CNT_W       = 32
) (
    input logic                 clk,
    input logic                 rst_n,
    multicycle_control_if.master bus
);
    state_e           state_q;
    state_e           state_d;
    logic             abort_q;
    logic             abort_d;
    logic [CNT_W-1:0] retired_q;
    logic [CNT_W-1:0] retired_d;
    logic             waiting;
    logic             timeout;
    logic             retire;

    assign waiting = ((state_q == S_FETCH) ||
                      (state_q == S_MEM_RD) ||
                      (state_q == S_MEM_WR)) && !bus.mem_ready;

    mem_wait_timer #(
        .MEM_TIMEOUT(MEM_TIMEOUT)
    ) u_timer (
        .clk(clk),
        .rst_n(rst_n),
        .waiting(waiting),
        .timeout(timeout)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            abort_q   <= 1'b0;
            retired_q <= '0;
        end else begin
            state_q   <= state_d;
            abort_q   <= abort_d;
            retired_q <= retired_d;
        end
    end

    // A timeout reuses TRAP; abort_q tells the two causes apart there.
    always_comb begin
        state_d = state_q;
        abort_d = timeout;
        unique case (state_q)
            S_IDLE: state_d = S_FETCH;
            S_FETCH: begin
                if (bus.mem_ready) state_d = S_DECODE;
                else if (timeout) state_d = S_TRAP;
            end
            S_DECODE: state_d = decode_next(bus.opcode, bus.funct);
            S_MEM_ADDR: begin
                state_d = (bus.opcode == OP_SW) ? S_MEM_WR : S_MEM_RD;
            end
            S_MEM_RD: begin
                if (bus.mem_ready) state_d = S_MEM_WB;
                else if (timeout) state_d = S_TRAP;
            end
            S_MEM_WR: begin
                if (bus.mem_ready) state_d = S_FETCH;
                else if (timeout) state_d = S_TRAP;
            end
            S_EXEC_R: state_d = S_R_WB;
            S_EXEC_I: state_d = S_I_WB;
            default: state_d = S_FETCH;
        endcase
    end

    always_comb begin
        retire = 1'b0;
        if (state_d == S_FETCH) begin
            unique case (state_q)
                S_MEM_WB, S_MEM_WR, S_R_WB, S_I_WB,
                S_BRANCH, S_JUMP, S_JAL, S_JR: retire = 1'b1;
                default: retire = 1'b0;
            endcase
        end
        retired_d = retire ? retired_q + 1'b1 : retired_q;
    end

    always_comb begin
        bus.pc_write      = 1'b0;
        bus.pc_write_cond = 1'b0;
        bus.branch_ne     = 1'b0;
        bus.iord          = 1'b0;
        bus.mem_read      = 1'b0;
        bus.mem_write     = 1'b0;
        bus.ir_write      = 1'b0;
        bus.reg_write     = 1'b0;
        bus.reg_dst       = RD_RT;
        bus.mem_to_reg    = M2R_ALU;
        bus.alu_src_a     = 1'b0;
        bus.alu_src_b     = SRCB_REG;
        bus.zero_ext      = 1'b0;
        bus.alu_op        = ALU_ADD;
        bus.pc_source     = PCS_ALU;
        bus.illegal_op    = 1'b0;
        bus.mem_abort     = 1'b0;
        unique case (state_q)
            S_FETCH: begin
                bus.mem_read  = 1'b1;
                bus.alu_src_b = SRCB_FOUR;
                bus.ir_write  = bus.mem_ready;
                bus.pc_write  = bus.mem_ready;
            end
            S_DECODE: bus.alu_src_b = SRCB_IMM_SH;
            S_MEM_ADDR: begin
                bus.alu_src_a = 1'b1;
                bus.alu_src_b = SRCB_IMM;
            end
            S_MEM_RD: begin
                bus.mem_read = 1'b1;
                bus.iord     = 1'b1;
            end
            S_MEM_WB: begin
                bus.reg_write  = 1'b1;
                bus.mem_to_reg = M2R_MDR;
            end
            S_MEM_WR: begin
                bus.mem_write = 1'b1;
                bus.iord      = 1'b1;
            end
            S_EXEC_R: begin
                bus.alu_src_a = 1'b1;
                bus.alu_op    = ALU_FUNCT;
            end
            S_R_WB: begin
                bus.reg_write = 1'b1;
                bus.reg_dst   = RD_RD;
            end
            S_EXEC_I: begin
                bus.alu_src_a = 1'b1;
                bus.alu_src_b = SRCB_IMM;
                bus.alu_op    = imm_alu_op(bus.opcode);
                bus.zero_ext  = imm_zero_ext(bus.opcode);
            end
            S_I_WB: bus.reg_write = 1'b1;
            S_BRANCH: begin
                bus.alu_src_a     = 1'b1;
                bus.alu_op        = ALU_SUB;
                bus.pc_write_cond = 1'b1;
                bus.pc_source     = PCS_ALUOUT;
                bus.branch_ne     = bus.opcode[0];
            end
            S_JUMP: begin
                bus.pc_write  = 1'b1;
                bus.pc_source = PCS_JUMP;
            end
            S_JAL: begin
                bus.pc_write   = 1'b1;
                bus.pc_source  = PCS_JUMP;
                bus.reg_write  = 1'b1;
                bus.reg_dst    = RD_RA;
                bus.mem_to_reg = M2R_PC;
            end
            S_JR: begin
                bus.pc_write  = 1'b1;
                bus.pc_source = PCS_REG;
            end
            S_TRAP: begin
                bus.illegal_op = !abort_q;
                bus.mem_abort  = abort_q;
            end
            default: ;
        endcase
    end

    assign bus.retired = retired_q;
    assign bus.state   = state_q;
endmodule

// File: doc/multicycle_control.md
# multicycle_control

Multi-cycle successor to the single-cycle MIPS control decoder. It sequences each instruction through fetch, decode, execute, memory and write-back states, and drives the datapath enables cycle by cycle. Unlike the single-cycle decoder, it:
- stretches memory states with a `mem_ready` handshake and aborts on timeout;
- traps undefined opcodes;
- counts retired instructions.

It sits between the instruction register and the shared multi-cycle datapath (PC, IR, register file, ALU, unified memory).

## Interface
Parameters:
- `MEM_TIMEOUT`, 15: maximum wait cycles in any memory state before abort; legal range 1..255.
- `CNT_W`, 32: width of the retired-instruction counter.

Ports:
- `clk` in 1: single clock, all state updates on the rising edge.
- `rst_n` in 1: reset, synchronous, active-low.
- `opcode` in 6: IR[31:26], valid from DECODE onward.
- `funct` in 6: IR[5:0].
- `zero` in 1: ALU zero flag, sampled in BRANCH.
- `mem_ready` in 1: memory has completed the current access this cycle.
- `pc_write` out 1: unconditional PC load.
- `pc_write_cond` out 1: PC load if the branch condition holds.
- `branch_ne` out 1: 1 selects bne, 0 selects beq.
- `iord` out 1: memory address source; 0 is PC, 1 is ALUOut.
- `mem_read` out 1: memory read request.
- `mem_write` out 1: memory write request.
- `ir_write` out 1: load the instruction register.
- `reg_write` out 1: register file write enable.
- `reg_dst` out 2: destination register; 0 is rt, 1 is rd, 2 is $31.
- `mem_to_reg` out 2: write-back source; 0 is ALUOut, 1 is MDR, 2 is PC.
- `alu_src_a` out 1: 0 is PC, 1 is register A.
- `alu_src_b` out 2: 0 is register B, 1 is constant 4, 2 is extended immediate, 3 is extended immediate shifted left by 2.
- `zero_ext` out 1: 1 zero-extends the immediate (andi/ori/xori).
- `alu_op` out 3: 0 add, 1 sub, 2 use funct, 3 and, 4 or, 5 xor.
- `pc_source` out 2: 0 is ALU result, 1 is ALUOut, 2 is jump target, 3 is register A (jr).
- `illegal_op` out 1: one-cycle pulse on an undefined opcode.
- `mem_abort` out 1: one-cycle pulse on a memory timeout.
- `retired` out CNT_W: count of completed instructions.
- `state` out 4: current state, for debug.

## Operation
- States: IDLE, FETCH, DECODE, MEM_ADDR, MEM_RD, MEM_WB, MEM_WR, EXEC_R, R_WB, EXEC_I, I_WB, BRANCH, JUMP, JAL, JR, TRAP.
- All outputs are Moore, decoded from `state` only. Any signal not listed for a state is 0.
- IDLE: all outputs 0. Next state is FETCH.
- FETCH: `mem_read`=1, `iord`=0, `alu_src_a`=0, `alu_src_b`=1, `alu_op`=add.
  - `ir_write` and `pc_write` are asserted only in the cycle where `mem_ready`=1; that cycle advances to DECODE.
- DECODE: `alu_src_a`=0, `alu_src_b`=3, `alu_op`=add (branch target into ALUOut). Dispatch on opcode:
  - 0x00 with funct 0x08 goes to JR; other 0x00 goes to EXEC_R.
  - 0x23 and 0x2B go to MEM_ADDR.
  - 0x04 and 0x05 go to BRANCH.
  - 0x02 goes to JUMP; 0x03 goes to JAL.
  - 0x08, 0x09, 0x0C, 0x0D and 0x0E go to EXEC_I.
  - Anything else goes to TRAP.
- MEM_ADDR: `alu_src_a`=1, `alu_src_b`=2, `alu_op`=add. Next state is MEM_RD for lw, MEM_WR for sw.
- MEM_RD: `mem_read`=1, `iord`=1. On `mem_ready`, go to MEM_WB.
- MEM_WB: `reg_write`=1, `reg_dst`=0, `mem_to_reg`=1. Next state is FETCH.
- MEM_WR: `mem_write`=1, `iord`=1. On `mem_ready`, go to FETCH.
- EXEC_R: `alu_src_a`=1, `alu_src_b`=0, `alu_op`=funct. Next state is R_WB.
- R_WB: `reg_write`=1, `reg_dst`=1, `mem_to_reg`=0. Next state is FETCH.
- EXEC_I: `alu_src_a`=1, `alu_src_b`=2. The opcode selects the operation:
  - addi and addiu: `alu_op`=add.
  - andi: `alu_op`=and.
  - ori: `alu_op`=or.
  - xori: `alu_op`=xor.
  - `zero_ext`=1 for andi, ori and xori.
  - Next state is I_WB.
- I_WB: `reg_write`=1, `reg_dst`=0, `mem_to_reg`=0. Next state is FETCH.
- BRANCH: `alu_src_a`=1, `alu_src_b`=0, `alu_op`=sub, `pc_write_cond`=1, `pc_source`=1, `branch_ne`=opcode[0]. Next state is FETCH.
- JUMP: `pc_write`=1, `pc_source`=2. Next state is FETCH.
- JAL: `pc_write`=1, `pc_source`=2, `reg_write`=1, `reg_dst`=2, `mem_to_reg`=2. Next state is FETCH.
  - The PC written to $31 is the PC+4 value loaded in FETCH, because the new PC only updates at the end of this cycle.
- JR: `pc_write`=1, `pc_source`=3. Next state is FETCH.
- TRAP: `illegal_op`=1, no writes. Next state is FETCH. The trapped instruction is not retired.
- Wait counter:
  - 8 bits; cleared on entry to FETCH, MEM_RD and MEM_WR.
  - Increments each cycle the FSM waits in one of those states with `mem_ready`=0.
  - If `mem_ready`=0 and the counter equals `MEM_TIMEOUT`, the next state is TRAP-like abort: `mem_abort` is pulsed in the following cycle and the FSM returns to FETCH.
  - `mem_ready` in the same cycle as the limit wins: the access completes.
- `retired` increments by 1 on each transition into FETCH from MEM_WB, MEM_WR, R_WB, I_WB, BRANCH, JUMP, JAL or JR. It wraps modulo 2^CNT_W.

## Timing
- Reset: while `rst_n`=0 at an edge, the state becomes IDLE, `retired` becomes 0 and the wait counter becomes 0. All outputs are 0 in IDLE.
- Reset sampled mid-instruction or mid-wait abandons the instruction; no write enable is asserted after that edge.
- Latency with `mem_ready` tied to 1:
  - 3 cycles: beq, bne, j, jal, jr.
  - 4 cycles: R-type, I-type ALU, sw.
  - 5 cycles: lw.
  - Each memory state adds one cycle per `mem_ready`=0 cycle.
- `mem_read` and `mem_write` are held stable, with the address source unchanged, until the `mem_ready` cycle or the abort.
- `illegal_op` and `mem_abort` are each high for exactly one cycle per event.

## Structure
- Package `mips_ctrl_pkg` holds:
  - the state enum (4-bit);
  - opcode and funct constants: OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_J, OP_JAL, OP_ADDI, OP_ADDIU, OP_ANDI, OP_ORI, OP_XORI, FN_JR;
  - the `alu_op`, `alu_src_b`, `pc_source`, `reg_dst` and `mem_to_reg` encodings.
- One sub-module: `mem_wait_timer`, holding the wait counter and timeout compare with `MEM_TIMEOUT` as its parameter.

## Test plan
- Reset, `mem_ready`=1, opcode 0x00 funct 0x20: `state` sequence IDLE, FETCH, DECODE, EXEC_R, R_WB, FETCH. `reg_write`=1 with `reg_dst`=1 only in R_WB, then `retired`=1.
- lw with `mem_ready` low for 3 cycles in MEM_RD: `mem_read`=1 and `iord`=1 held for 4 cycles. `reg_write` is asserted with `mem_to_reg`=1 one cycle after `mem_ready`.
- bne with `zero`=0 and beq with `zero`=1: each takes 3 cycles. In BRANCH, `pc_write_cond`=1 and `branch_ne` equals opcode[0].
- jal: JAL state shows `pc_write`=1, `reg_dst`=2, `mem_to_reg`=2 and `pc_source`=2 in a single cycle.
- Opcode 0x3F: TRAP follows DECODE. `illegal_op` pulses once, `retired` is unchanged, and the FSM is back in FETCH.
- `MEM_TIMEOUT`=4 with `mem_ready` stuck at 0 in FETCH: `mem_abort` pulses after 5 waiting cycles.
  - Then assert `rst_n`=0 mid-MEM_WR and require IDLE with all outputs 0 on the next cycle.
